// File: rtl/wb_regfile_hilo_pkg.sv
// rtl/wb_regfile_hilo_pkg.sv - funct codes and width defaults for the write-back stage
package wb_regfile_hilo_pkg;

    localparam int DATA_W_DEF = 32;
    localparam int ADDR_W_DEF = 5;
    localparam int CNT_W_DEF  = 32;

    localparam logic [5:0] FN_MOVZ  = 6'h0A;
    localparam logic [5:0] FN_MOVN  = 6'h0B;
    localparam logic [5:0] FN_MFHI  = 6'h10;
    localparam logic [5:0] FN_MTHI  = 6'h11;
    localparam logic [5:0] FN_MFLO  = 6'h12;
    localparam logic [5:0] FN_MTLO  = 6'h13;
    localparam logic [5:0] FN_MULT  = 6'h18;
    localparam logic [5:0] FN_MULTU = 6'h19;
    localparam logic [5:0] FN_DIV   = 6'h1A;
    localparam logic [5:0] FN_DIVU  = 6'h1B;

    function automatic logic is_muldiv(input logic [5:0] fn);
        return (fn == FN_MULT) || (fn == FN_MULTU) || (fn == FN_DIV) || (fn == FN_DIVU);
    endfunction

endpackage

// File: rtl/wb_regfile_hilo_regfile_2r1w.sv
// rtl/wb_regfile_hilo_regfile_2r1w.sv - two-read one-write GPR array with write-first bypass
module regfile_2r1w
    import wb_regfile_hilo_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic              clk_i,
    input  logic              clr_i,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] waddr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic [ADDR_W-1:0] raddr1_i,
    input  logic [ADDR_W-1:0] raddr2_i,
    output logic [DATA_W-1:0] rdata1_o,
    output logic [DATA_W-1:0] rdata2_o
);

    localparam int NREGS = 2 ** ADDR_W;

    logic [DATA_W-1:0] regs_q [NREGS];

    always_ff @(posedge clk_i) begin
        if (clr_i) begin
            for (int i = 0; i < NREGS; i++) begin
                regs_q[i] <= '0;
            end
        end else if (we_i && (waddr_i != '0)) begin
            regs_q[waddr_i] <= wdata_i;
        end
    end

    // $0 is forced on read so the array entry never matters.
    always_comb begin
        if (raddr1_i == '0)
            rdata1_o = '0;
        else if (we_i && (raddr1_i == waddr_i))
            rdata1_o = wdata_i;
        else
            rdata1_o = regs_q[raddr1_i];

        if (raddr2_i == '0)
            rdata2_o = '0;
        else if (we_i && (raddr2_i == waddr_i))
            rdata2_o = wdata_i;
        else
            rdata2_o = regs_q[raddr2_i];
    end

endmodule

// File: rtl/wb_regfile_hilo.sv
// rtl/wb_regfile_hilo.sv - write-back stage: data select, movz/movn, HI/LO and commit counter
module wb_regfile_hilo
    import wb_regfile_hilo_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int CNT_W  = CNT_W_DEF
) (
    input  logic              Clk,
    input  logic              Clr,
    input  logic              WB_RegWrite,
    input  logic              WB_RegWrite2,
    input  logic              WB_MemtoReg,
    input  logic [DATA_W-1:0] WB_ReadData,
    input  logic [DATA_W-1:0] WB_ALUResult,
    input  logic [ADDR_W-1:0] WB_RegDstData,
    input  logic [DATA_W-1:0] WB_HI,
    input  logic [DATA_W-1:0] WB_LO,
    input  logic [5:0]        func_in,
    input  logic              WB_Zero,
    input  logic [ADDR_W-1:0] ReadReg1,
    input  logic [ADDR_W-1:0] ReadReg2,
    output logic [DATA_W-1:0] ReadData1,
    output logic [DATA_W-1:0] ReadData2,
    output logic [DATA_W-1:0] HI_out,
    output logic [DATA_W-1:0] LO_out,
    output logic [DATA_W-1:0] WB_WriteData,
    output logic              WB_WriteEn,
    output logic [ADDR_W-1:0] WB_WriteReg,
    output logic [CNT_W-1:0]  CommitCount
);

    logic [DATA_W-1:0] hi_q, hi_d;
    logic [DATA_W-1:0] lo_q, lo_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              cond;
    logic              hilo_commit;

    always_comb begin
        case (func_in)
            FN_MOVZ: cond = WB_Zero;
            FN_MOVN: cond = ~WB_Zero;
            default: cond = 1'b1;
        endcase

        // MFHI/MFLO see only the committed HI/LO, never this cycle's update.
        case (func_in)
            FN_MFHI: WB_WriteData = hi_q;
            FN_MFLO: WB_WriteData = lo_q;
            default: WB_WriteData = WB_MemtoReg ? WB_ReadData : WB_ALUResult;
        endcase

        WB_WriteEn = WB_RegWrite & (WB_RegDstData != '0) & cond & ~Clr;

        hi_d        = hi_q;
        lo_d        = lo_q;
        hilo_commit = 1'b0;
        if (WB_RegWrite2) begin
            if (is_muldiv(func_in)) begin
                hi_d        = WB_HI;
                lo_d        = WB_LO;
                hilo_commit = 1'b1;
            end else if (func_in == FN_MTHI) begin
                hi_d        = WB_ALUResult;
                hilo_commit = 1'b1;
            end else if (func_in == FN_MTLO) begin
                lo_d        = WB_ALUResult;
                hilo_commit = 1'b1;
            end
        end

        cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, (WB_WriteEn | hilo_commit)};
    end

    always_ff @(posedge Clk) begin
        if (Clr) begin
            hi_q  <= '0;
            lo_q  <= '0;
            cnt_q <= '0;
        end else begin
            hi_q  <= hi_d;
            lo_q  <= lo_d;
            cnt_q <= cnt_d;
        end
    end

    regfile_2r1w #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_regfile (
        .clk_i    (Clk),
        .clr_i    (Clr),
        .we_i     (WB_WriteEn),
        .waddr_i  (WB_RegDstData),
        .wdata_i  (WB_WriteData),
        .raddr1_i (ReadReg1),
        .raddr2_i (ReadReg2),
        .rdata1_o (ReadData1),
        .rdata2_o (ReadData2)
    );

    assign HI_out      = hi_q;
    assign LO_out      = lo_q;
    assign WB_WriteReg = WB_RegDstData;
    assign CommitCount = cnt_q;

endmodule
